// File: rtl/fifo_wr_arbiter_if.sv
`timescale 1ns/1ps
// fifo_wr_arbiter_if: requester-side and FIFO-write-side signals of the write-port arbiter.
//   req/req_data/req_last : per-requester word offer (requester i at slice i)
//   ack                   : one-hot, word of requester i written this cycle
//   grant/busy            : current owner and grant-held flag
//   fifo_wr_en/data/full  : FIFO write port
// master: the arbiter side. slave: requesters plus FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_wr_data;
  logic                  fifo_wr_full;

  modport master (
    input  req, req_data, req_last, fifo_wr_full,
    output ack, grant, busy, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    output req, req_data, req_last, fifo_wr_full,
    input  ack, grant, busy, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
`timescale 1ns/1ps
// fifo_wr_arbiter: round-robin sharing of one FIFO write port among NREQ requesters.
// A grant covers up to BURST words; it ends early on req_last or when the owner
// withdraws its request. FIFO full stalls the owner while it keeps the grant.
// Ports:
//   clk   : FIFO write clock
//   rst_n : synchronous active-low reset
//   bus   : fifo_wr_arbiter_if.master (requests, ack, grant, busy, FIFO write port)
module fifo_wr_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_wr_arbiter_if.master  bus
);

  localparam int unsigned OW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(BURST - 1);
  localparam logic [OW-1:0]    OWNER_RESET = OW'(NREQ - 1);
  localparam logic [NREQ-1:0]  ONE         = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state;
  logic [NREQ-1:0]   grant_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt;
  logic [OW-1:0]     owner;
  logic [OW-1:0]     last_owner;

  logic [WIDTH-1:0]  words [NREQ];
  logic [OW-1:0]     cand;
  logic [OW-1:0]     win_idx;
  logic              win_found;
  logic              own_req;
  logic              xfer;
  logic              burst_end;

  // Unpack the flat requester data bus.
  for (genvar g = 0; g < NREQ; g++) begin : g_words
    assign words[g] = bus.req_data[g*WIDTH +: WIDTH];
  end

  // Round-robin winner: first set req bit above last_owner, wrapping around.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = OW'((32'(last_owner) + k) % NREQ);
      if (!win_found && bus.req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // Owner transfer qualification; rst_n gating keeps the write strobe quiet during reset.
  assign own_req   = bus.req[owner];
  assign xfer      = (state == OWN) && rst_n && own_req && !bus.fifo_wr_full;
  assign burst_end = bus.req_last[owner] || (cnt == CNT_LAST);

  assign bus.fifo_wr_en   = xfer;
  assign bus.ack          = xfer ? grant_q : '0;
  assign bus.fifo_wr_data = ((state == OWN) && rst_n) ? words[owner] : '0;
  assign bus.grant        = grant_q;
  assign bus.busy         = busy_q;

  // Grant FSM; every release returns to IDLE for one arbitration cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      cnt        <= '0;
      owner      <= '0;
      last_owner <= OWNER_RESET;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state      <= OWN;
            grant_q    <= ONE << win_idx;
            busy_q     <= 1'b1;
            owner      <= win_idx;
            last_owner <= win_idx;
            cnt        <= '0;
          end
        end
        OWN: begin
          if (!own_req) begin
            state   <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            cnt     <= '0;
          end else if (!bus.fifo_wr_full) begin
            if (burst_end) begin
              state   <= IDLE;
              grant_q <= '0;
              busy_q  <= 1'b0;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
// tb_fifo_wr_arbiter: directed vectors with per-cycle literal expectations, a
// rule-level arbiter model compared on every cycle, and a data-integrity pass.
module tb_fifo_wr_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int BURST = 4;
  localparam int NW    = 10;
  localparam int PKT   = 5;
  localparam int MAXC  = 2000;

  logic clk = 1'b0;
  logic rst_n;

  fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bit_of(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    return NREQ'(1) << i;
  endfunction

  function automatic logic [WIDTH-1:0] word_of(input logic [NREQ*WIDTH-1:0] d, input int i);
    return WIDTH'(d >> (i * WIDTH));
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    int c;
    for (int k = 1; k <= NREQ; k++) begin
      c = (last + k) % NREQ;
      if (bit_of(r, c)) return c;
    end
    return 0;
  endfunction

  // Rule-level model: who owns the port and how many words it has moved.
  logic m_own   = 1'b0;
  int   m_owner = 0;
  int   m_cnt   = 0;
  int   m_last  = NREQ - 1;
  logic chk_en  = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_own   <= 1'b0;
      m_owner <= 0;
      m_cnt   <= 0;
      m_last  <= NREQ - 1;
      chk_en  <= 1'b1;
    end else if (!m_own) begin
      if (bus.req != '0) begin
        m_owner <= rr_pick(bus.req, m_last);
        m_last  <= rr_pick(bus.req, m_last);
        m_own   <= 1'b1;
        m_cnt   <= 0;
      end
    end else if (!bit_of(bus.req, m_owner)) begin
      m_own <= 1'b0;
    end else if (!bus.fifo_wr_full) begin
      if (bit_of(bus.req_last, m_owner) || m_cnt == BURST - 1) m_own <= 1'b0;
      else m_cnt <= m_cnt + 1;
    end
  end

  function automatic logic exp_wr();
    return m_own && rst_n && bit_of(bus.req, m_owner) && !bus.fifo_wr_full;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_grant", 64'(bus.grant), m_own ? 64'(onehot(m_owner)) : 64'd0);
      check("m_busy", 64'(bus.busy), 64'(m_own));
      check("m_wr_en", 64'(bus.fifo_wr_en), 64'(exp_wr()));
      check("m_ack", 64'(bus.ack), exp_wr() ? 64'(onehot(m_owner)) : 64'd0);
      check("m_wr_data", 64'(bus.fifo_wr_data),
            (m_own && rst_n) ? 64'(word_of(bus.req_data, m_owner)) : 64'd0);
    end
  end

  function automatic logic [WIDTH-1:0] dflt_word(input logic [NREQ-1:0] oh);
    logic [WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < NREQ; i++)
      if (bit_of(oh, i)) w = 16'hA0A0 + 16'(i) * 16'h1111;
    return w;
  endfunction

  // One cycle of directed stimulus with hand-computed grant/write expectations.
  task automatic cyc(input logic r_n, input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                     input logic f, input logic [NREQ-1:0] eg, input logic ew);
    rst_n            = r_n;
    bus.req          = r;
    bus.req_last     = l;
    bus.fifo_wr_full = f;
    @(negedge clk);
    check("grant", 64'(bus.grant), 64'(eg));
    check("busy", 64'(bus.busy), 64'(|eg));
    check("wr_en", 64'(bus.fifo_wr_en), 64'(ew));
    check("ack", 64'(bus.ack), ew ? 64'(eg) : 64'd0);
    check("wr_data", 64'(bus.fifo_wr_data), (r_n && |eg) ? 64'(dflt_word(eg)) : 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    bus.req          = '1;
    bus.req_last     = '0;
    bus.fifo_wr_full = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_grant", 64'(bus.grant), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    check("rst_ack", 64'(bus.ack), 64'd0);
    check("rst_wr_data", 64'(bus.fifo_wr_data), 64'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    bus.req = '0;
  endtask

  int                    seq [NREQ];
  int                    nxt [NREQ];
  logic [NREQ-1:0]       ack_now;
  logic [WIDTH-1:0]      cap [$];
  logic [NREQ*WIDTH-1:0] rd;
  logic [NREQ*WIDTH-1:0] tmp;
  logic [NREQ-1:0]       rq;
  logic [NREQ-1:0]       rl;
  logic [WIDTH-1:0]      w;
  int                    ncyc;
  int                    id;
  logic                  done;

  initial begin
    rst_n            = 1'b0;
    bus.req          = '0;
    bus.req_last     = '0;
    bus.fifo_wr_full = 1'b0;
    bus.req_data     = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};

    // Single requester, 6 words, BURST=4: 4 writes, bubble, re-grant, 2 writes.
    do_reset();
    cyc(1, 4'b0001, 4'b0000, 0, 4'b0000, 0);
    cyc(1, 4'b0001, 4'b0000, 0, 4'b0001, 1);
    cyc(1, 4'b0001, 4'b0000, 0, 4'b0001, 1);
    cyc(1, 4'b0001, 4'b0000, 0, 4'b0001, 1);
    cyc(1, 4'b0001, 4'b0000, 0, 4'b0001, 1);
    cyc(1, 4'b0001, 4'b0000, 0, 4'b0000, 0);
    cyc(1, 4'b0001, 4'b0000, 0, 4'b0001, 1);
    cyc(1, 4'b0001, 4'b0000, 0, 4'b0001, 1);
    cyc(1, 4'b0000, 4'b0000, 0, 4'b0001, 0);
    cyc(1, 4'b0000, 4'b0000, 0, 4'b0000, 0);

    // Round-robin with single-word packets: grants 0,1,2,3,0.
    do_reset();
    cyc(1, 4'b1111, 4'b1111, 0, 4'b0000, 0);
    cyc(1, 4'b1111, 4'b1111, 0, 4'b0001, 1);
    cyc(1, 4'b1111, 4'b1111, 0, 4'b0000, 0);
    cyc(1, 4'b1111, 4'b1111, 0, 4'b0010, 1);
    cyc(1, 4'b1111, 4'b1111, 0, 4'b0000, 0);
    cyc(1, 4'b1111, 4'b1111, 0, 4'b0100, 1);
    cyc(1, 4'b1111, 4'b1111, 0, 4'b0000, 0);
    cyc(1, 4'b1111, 4'b1111, 0, 4'b1000, 1);
    cyc(1, 4'b1111, 4'b1111, 0, 4'b0000, 0);
    cyc(1, 4'b1111, 4'b1111, 0, 4'b0001, 1);
    cyc(1, 4'b0000, 4'b0000, 0, 4'b0000, 0);

    // Backpressure on owner 2 at cnt=1 for 3 cycles, then 2 words ending in last.
    cyc(1, 4'b0100, 4'b0000, 0, 4'b0000, 0);
    cyc(1, 4'b0100, 4'b0000, 0, 4'b0100, 1);
    cyc(1, 4'b0100, 4'b0000, 1, 4'b0100, 0);
    cyc(1, 4'b0100, 4'b0000, 1, 4'b0100, 0);
    cyc(1, 4'b0100, 4'b0000, 1, 4'b0100, 0);
    cyc(1, 4'b0100, 4'b0000, 0, 4'b0100, 1);
    cyc(1, 4'b0100, 4'b0100, 0, 4'b0100, 1);
    cyc(1, 4'b0000, 4'b0000, 0, 4'b0000, 0);

    // Withdrawal: owner 1 drops after one word; next grant goes to 2.
    cyc(1, 4'b0010, 4'b0000, 0, 4'b0000, 0);
    cyc(1, 4'b1110, 4'b0000, 0, 4'b0010, 1);
    cyc(1, 4'b1100, 4'b0000, 0, 4'b0010, 0);
    cyc(1, 4'b1100, 4'b0000, 0, 4'b0000, 0);
    cyc(1, 4'b1100, 4'b0100, 0, 4'b0100, 1);
    cyc(1, 4'b0000, 4'b0000, 0, 4'b0000, 0);

    // Reset in the middle of a burst of owner 3; requester 0 wins afterwards.
    cyc(1, 4'b1000, 4'b0000, 0, 4'b0000, 0);
    cyc(1, 4'b1000, 4'b0000, 0, 4'b1000, 1);
    cyc(0, 4'b1000, 4'b0000, 0, 4'b1000, 0);
    cyc(1, 4'b1001, 4'b0000, 0, 4'b0000, 0);
    cyc(1, 4'b1001, 4'b0001, 0, 4'b0001, 1);
    cyc(1, 4'b0000, 4'b0000, 0, 4'b0000, 0);

    // Data integrity: 2 packets of PKT words per requester, tagged {id,seq}, random full.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      seq[i] = 0;
      nxt[i] = 0;
    end
    ncyc = 0;
    done = 1'b0;
    while (!done && ncyc < MAXC) begin
      rd = '0;
      rq = '0;
      rl = '0;
      for (int i = 0; i < NREQ; i++) begin
        w   = (16'(i) << 12) | 16'(seq[i] % NW);
        tmp = {{((NREQ-1)*WIDTH){1'b0}}, w};
        rd  = rd | (tmp << (i * WIDTH));
        if (seq[i] < NW) rq = rq | onehot(i);
        if ((seq[i] % PKT) == PKT - 1) rl = rl | onehot(i);
      end
      bus.req_data     = rd;
      bus.req          = rq;
      bus.req_last     = rl;
      bus.fifo_wr_full = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      ack_now = bus.ack;
      if (bus.fifo_wr_en) cap.push_back(bus.fifo_wr_data);
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++)
        if (bit_of(ack_now, i)) seq[i] = seq[i] + 1;
      done = 1'b1;
      for (int i = 0; i < NREQ; i++)
        if (seq[i] < NW) done = 1'b0;
      ncyc++;
    end
    check("integ_timeout", 64'(done), 64'd1);
    bus.req      = '0;
    bus.req_last = '0;
    bus.fifo_wr_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("integ_total", 64'(cap.size()), 64'(NREQ * NW));
    foreach (cap[k]) begin
      w  = cap[k];
      id = int'(w[15:12]);
      if (id < NREQ) begin
        check("integ_order", 64'(w[11:0]), 64'(nxt[id]));
        nxt[id] = nxt[id] + 1;
      end else begin
        check("integ_id", 64'(id), 64'(NREQ - 1));
      end
    end
    for (int i = 0; i < NREQ; i++) check("integ_count", 64'(nxt[i]), 64'(NW));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of one asynchronous FIFO between NREQ requesters in the FIFO's write clock domain. Each grant covers a bounded burst of words. The burst ends early on a packet-last marker or when the owner withdraws its request. Write-full backpressure stalls the owner without losing its grant.

## Interface
Parameters:
- WIDTH, 16, data word width; equals the FIFO data width.
- NREQ, 4, number of requesters; legal range 2..8.
- BURST, 4, maximum words per grant; minimum 1.

Ports:
- clk  in  1  single clock; connects to the FIFO write clock. One clock; reset is synchronous and active-low.
- rst_n  in  1  synchronous, active-low reset.
- req  in  NREQ  requester i has a valid word this cycle.
- req_data  in  NREQ*WIDTH  word of requester i at bits [i*WIDTH +: WIDTH].
- req_last  in  NREQ  the word of requester i is the last word of its packet.
- ack  out  NREQ  one-hot; the word of requester i is written this cycle.
- grant  out  NREQ  registered one-hot current owner; all-zero when idle.
- busy  out  1  registered; high while a grant is held.
- fifo_wr_en  out  1  write strobe to the FIFO.
- fifo_wr_data  out  WIDTH  write data to the FIFO.
- fifo_wr_full  in  1  FIFO write-full flag.

## Operation
States:
- IDLE: no grant is held.
- OWN: requester `owner` holds the port.

IDLE:
- If any req bit is high at a clock edge, the winner is the first set bit searching upward from (last_owner+1) mod NREQ, with wrap-around.
- On that edge, register grant=onehot(winner), owner=winner, last_owner=winner and cnt=0, and move to OWN.
- If no req bit is high, stay in IDLE.

OWN, transfer condition: xfer = req[owner] & ~fifo_wr_full.
- fifo_wr_en = xfer. It is combinational and is also forced to 0 while rst_n=0.
- ack[owner] = xfer. All other ack bits are 0.
- fifo_wr_data = req_data slice of owner. It is 0 in IDLE.
- On xfer with req_last[owner]=1, or with cnt==BURST-1: release, meaning grant←0 and state←IDLE.
- On xfer otherwise: cnt←cnt+1.
- If req[owner]=0 (whether or not the FIFO is full): release with no write.
- If req[owner]=1 and fifo_wr_full=1: stall. Hold grant and cnt, and write nothing.

Other rules:
- Every release passes through one IDLE cycle before the next grant. This gives a fixed 1-cycle arbitration bubble.
- cnt width is $clog2(BURST) bits (1 bit when BURST=1). cnt never exceeds BURST-1.
- A requester must hold req and its data stable until ack. The block never drops or duplicates a word.
- Requests from non-owners are ignored during OWN. They are considered at the next IDLE.

## Timing
Reset (rst_n=0 at an edge):
- state=IDLE, grant=0, busy=0, cnt=0, last_owner=NREQ-1, so requester 0 wins first.
- ack=0, fifo_wr_en=0 and fifo_wr_data=0 for as long as rst_n is low.
- A reset in the middle of a burst drops the grant at that edge and writes no partial word.

Latency:
- A req first seen in IDLE at edge k gives grant/busy high after edge k.
- The first write can occur in cycle k+1 (zero-latency ack in OWN).
- Throughput is 1 word/cycle during a burst.
- Best case is BURST words per BURST+1 cycles per grant.

Simultaneous events:
- When last and cnt==BURST-1 coincide, there is a single release.
- When fifo_wr_full deasserts in the same cycle as req[owner] stays high, the transfer happens that cycle.
- req rising in the same cycle as a release is arbitrated in the following IDLE cycle.

## Test plan
- Single requester: req[0] held for 6 words, no last, BURST=4. Required: 4 consecutive writes, 1 idle cycle, re-grant to requester 0, then 2 writes.
- Round-robin: req=4'b1111 continuously, each packet 1 word with last=1. Required grant sequence 0,1,2,3,0. Each grant is 1 write cycle followed by 1 IDLE cycle.
- Backpressure: owner 2 mid-burst with cnt=1 and fifo_wr_full high for 3 cycles. Required: grant held, ack=0, fifo_wr_en=0, cnt stays 1. After full drops, the remaining 2 words are written and the grant is released.
- Withdrawal: owner 1 drops req after 1 word while others request. Required: release that cycle with no write, and the next grant goes to 2.
- Reset mid-burst: rst_n low for 1 cycle during a burst of owner 3. Required: grant=0, busy=0, no write during reset, and the next grant goes to requester 0.
- Data integrity: four requesters each send 5-word packets tagged {id,seq} into a model FIFO with random full. Required: the per-requester order is preserved, and no word is lost or duplicated.
